// File: rtl/seq_stack_pkg.sv
// Shared definitions for the microprogram sequencer return-address stack.
package seq_stack_pkg;

    // Default AM2910 geometry
    localparam int unsigned DEF_WIDTH = 12;
    localparam int unsigned DEF_DEPTH = 5;

    // Behaviour of a push (without pop) while the stack is full
    localparam int unsigned OVF_OVERWRITE = 0;
    localparam int unsigned OVF_DISCARD   = 1;

    // Per-cycle operation after priority resolution
    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_CLEAR   = 3'd1,
        OP_REPLACE = 3'd2,
        OP_PUSH    = 3'd3,
        OP_POP     = 3'd4
    } stack_op_e;

    // Resolve request lines: clear > push+pop > push > pop > hold
    function automatic stack_op_e decode_op(input logic clr, input logic push, input logic pop);
        if (clr)              return OP_CLEAR;
        else if (push && pop) return OP_REPLACE;
        else if (push)        return OP_PUSH;
        else if (pop)         return OP_POP;
        else                  return OP_HOLD;
    endfunction

endpackage

// File: rtl/seq_stack.sv
// Parametrised LIFO return-address stack with occupancy count, replace-top,
// sticky overflow/underflow flags and selectable full-push policy.
module seq_stack
    import seq_stack_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned DEPTH    = DEF_DEPTH,
    parameter int unsigned OVF_MODE = OVF_OVERWRITE
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_en,
    input  logic                       pop_en,
    input  logic                       clear_en,
    input  logic                       err_clr,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    // Reject unsupported geometries at elaboration
    if (DEPTH < 2 || DEPTH > 64 || WIDTH < 1) begin : g_param_check
        $error("seq_stack: DEPTH must be 2..64 and WIDTH >= 1");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] sp;
    logic [CNT_W-1:0] sp_nxt;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             wr_en;
    logic             ovf_set;
    logic             unf_set;
    logic             is_full;
    logic             is_empty;
    stack_op_e        op;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CNT_W'(DEPTH));
    assign top_idx  = is_empty ? '0 : IDX_W'(sp - CNT_W'(1));
    assign op       = decode_op(clear_en, push_en, pop_en);

    // Status and top-of-stack view, derived only from registered state
    assign count    = sp;
    assign full     = is_full;
    assign empty    = is_empty;
    assign data_out = is_empty ? '0 : mem[top_idx];

    // Next pointer, write strobe/index and error events for this cycle
    always_comb begin
        sp_nxt  = sp;
        wr_en   = 1'b0;
        wr_idx  = top_idx;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_CLEAR: begin
                sp_nxt = '0;
            end
            OP_REPLACE: begin
                // On an empty stack this degenerates to a plain push
                wr_en = 1'b1;
                if (is_empty) begin
                    wr_idx = '0;
                    sp_nxt = CNT_W'(1);
                end else begin
                    wr_idx = top_idx;
                end
            end
            OP_PUSH: begin
                if (!is_full) begin
                    wr_en  = 1'b1;
                    wr_idx = IDX_W'(sp);
                    sp_nxt = sp + CNT_W'(1);
                end else begin
                    ovf_set = 1'b1;
                    if (OVF_MODE == OVF_OVERWRITE) begin
                        wr_en  = 1'b1;
                        wr_idx = IDX_W'(DEPTH - 1);
                    end
                end
            end
            OP_POP: begin
                if (!is_empty) begin
                    sp_nxt = sp - CNT_W'(1);
                end else begin
                    unf_set = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer and sticky flags; a new error event overrides err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= sp_nxt;
            overflow  <= ovf_set | (overflow & ~err_clr);
            underflow <= unf_set | (underflow & ~err_clr);
        end
    end

    // Storage array; contents are don't-care after reset so it carries none
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= data_in;
        end
    end

endmodule

// File: tb/tb_seq_stack.sv
// Self-checking bench for seq_stack: directed scenarios on the default
// geometry in both full-push policies, then a randomized run on a 16x17
// stack against a queue-based reference model.
module tb_seq_stack;
    import seq_stack_pkg::*;

    localparam int unsigned GW = 16;
    localparam int unsigned GD = 17;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // Shared stimulus for the two default-geometry instances
    logic        push_en = 1'b0, pop_en = 1'b0, clear_en = 1'b0, err_clr = 1'b0;
    logic [11:0] data_in = '0;

    logic [11:0] d0_out, d1_out;
    logic [2:0]  d0_cnt, d1_cnt;
    logic        d0_full, d0_empty, d0_ovf, d0_unf;
    logic        d1_full, d1_empty, d1_ovf, d1_unf;

    // Generic-geometry instance signals
    logic          g_push = 1'b0, g_pop = 1'b0, g_clear = 1'b0, g_eclr = 1'b0;
    logic [GW-1:0] g_din = '0;
    logic [GW-1:0] g_out;
    logic [4:0]    g_cnt;
    logic          g_full, g_empty, g_ovf, g_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_stack #(.WIDTH(12), .DEPTH(5), .OVF_MODE(OVF_OVERWRITE)) u_d0 (
        .clk(clk), .reset_n(reset_n), .push_en(push_en), .pop_en(pop_en),
        .clear_en(clear_en), .err_clr(err_clr), .data_in(data_in),
        .data_out(d0_out), .count(d0_cnt), .full(d0_full), .empty(d0_empty),
        .overflow(d0_ovf), .underflow(d0_unf)
    );

    seq_stack #(.WIDTH(12), .DEPTH(5), .OVF_MODE(OVF_DISCARD)) u_d1 (
        .clk(clk), .reset_n(reset_n), .push_en(push_en), .pop_en(pop_en),
        .clear_en(clear_en), .err_clr(err_clr), .data_in(data_in),
        .data_out(d1_out), .count(d1_cnt), .full(d1_full), .empty(d1_empty),
        .overflow(d1_ovf), .underflow(d1_unf)
    );

    seq_stack #(.WIDTH(GW), .DEPTH(GD), .OVF_MODE(OVF_OVERWRITE)) u_gen (
        .clk(clk), .reset_n(reset_n), .push_en(g_push), .pop_en(g_pop),
        .clear_en(g_clear), .err_clr(g_eclr), .data_in(g_din),
        .data_out(g_out), .count(g_cnt), .full(g_full), .empty(g_empty),
        .overflow(g_ovf), .underflow(g_unf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock with the given requests on the default-geometry pair
    task automatic cyc(input logic p, input logic q, input logic c, input logic e,
                       input logic [11:0] d);
        push_en = p; pop_en = q; clear_en = c; err_clr = e; data_in = d;
        @(posedge clk);
        #1;
        push_en = 1'b0; pop_en = 1'b0; clear_en = 1'b0; err_clr = 1'b0;
    endtask

    // Same expectations on both default-geometry instances
    task automatic chk_pair(input string tag, input int cnt, input int dout,
                            input bit ovf, input bit unf);
        check({tag, " d0 count"}, 32'(d0_cnt), 32'(cnt));
        check({tag, " d1 count"}, 32'(d1_cnt), 32'(cnt));
        check({tag, " d0 data"},  32'(d0_out), 32'(dout));
        check({tag, " d1 data"},  32'(d1_out), 32'(dout));
        check({tag, " d0 full"},  32'(d0_full), 32'(cnt == 5));
        check({tag, " d1 full"},  32'(d1_full), 32'(cnt == 5));
        check({tag, " d0 empty"}, 32'(d0_empty), 32'(cnt == 0));
        check({tag, " d1 empty"}, 32'(d1_empty), 32'(cnt == 0));
        check({tag, " d0 ovf"},   32'(d0_ovf), 32'(ovf));
        check({tag, " d1 ovf"},   32'(d1_ovf), 32'(ovf));
        check({tag, " d0 unf"},   32'(d0_unf), 32'(unf));
        check({tag, " d1 unf"},   32'(d1_unf), 32'(unf));
    endtask

    // Reference model for the generic instance
    logic [GW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_unf = 1'b0;

    task automatic model_step(input logic p, input logic q, input logic c, input logic e,
                              input logic [GW-1:0] d);
        bit nov = m_ovf && !e;
        bit nun = m_unf && !e;
        if (c) begin
            mq.delete();
        end else if (p && q) begin
            if (mq.size() == 0) mq.push_back(d);
            else                mq[mq.size()-1] = d;
        end else if (p) begin
            if (mq.size() < GD) mq.push_back(d);
            else begin
                nov = 1'b1;
                mq[GD-1] = d;
            end
        end else if (q) begin
            if (mq.size() == 0) nun = 1'b1;
            else                void'(mq.pop_back());
        end
        m_ovf = nov;
        m_unf = nun;
    endtask

    task automatic gen_cyc(input logic p, input logic q, input logic c, input logic e,
                           input logic [GW-1:0] d);
        g_push = p; g_pop = q; g_clear = c; g_eclr = e; g_din = d;
        model_step(p, q, c, e, d);
        @(posedge clk);
        #1;
        check("gen count", 32'(g_cnt), 32'(mq.size()));
        check("gen data",  32'(g_out), (mq.size() == 0) ? 32'd0 : 32'(mq[mq.size()-1]));
        check("gen full",  32'(g_full),  32'(mq.size() == GD));
        check("gen empty", 32'(g_empty), 32'(mq.size() == 0));
        check("gen ovf",   32'(g_ovf), 32'(m_ovf));
        check("gen unf",   32'(g_unf), 32'(m_unf));
    endtask

    logic [11:0] seq [5];

    initial begin
        seq[0] = 12'hAAA; seq[1] = 12'hBBB; seq[2] = 12'hCCC; seq[3] = 12'hDDD; seq[4] = 12'hEEE;

        // T1: reset values, then asynchronous reset in the middle of a push
        reset_n = 1'b0;
        #15;
        chk_pair("t1 reset", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'hAAA);
        chk_pair("t1 push", 1, 12'hAAA, 1'b0, 1'b0);
        push_en = 1'b1; data_in = 12'hBBB;
        #2;
        reset_n = 1'b0;
        #1;
        chk_pair("t1 async", 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        push_en = 1'b0;
        chk_pair("t1 held", 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;

        // T2: fill and drain
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, seq[i]);
        chk_pair("t2 full", 5, 12'hEEE, 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) begin
            check("t2 pop d0", 32'(d0_out), 32'(seq[i]));
            check("t2 pop d1", 32'(d1_out), 32'(seq[i]));
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        end
        chk_pair("t2 drained", 0, 0, 1'b0, 1'b0);

        // T3: push on full under both policies, err_clr versus new event
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, seq[i]);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'hFFF);
        check("t3 d0 data", 32'(d0_out), 32'h0FFF);
        check("t3 d1 data", 32'(d1_out), 32'h0EEE);
        check("t3 d0 cnt", 32'(d0_cnt), 32'd5);
        check("t3 d1 cnt", 32'(d1_cnt), 32'd5);
        check("t3 d0 ovf", 32'(d0_ovf), 32'd1);
        check("t3 d1 ovf", 32'(d1_ovf), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'h123);
        check("t3 clr+evt d0 ovf", 32'(d0_ovf), 32'd1);
        check("t3 clr+evt d1 ovf", 32'(d1_ovf), 32'd1);
        check("t3 clr+evt d0 data", 32'(d0_out), 32'h0123);
        check("t3 clr+evt d1 data", 32'(d1_out), 32'h0EEE);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        check("t3 errclr d0 ovf", 32'(d0_ovf), 32'd0);
        check("t3 errclr d1 ovf", 32'(d1_ovf), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        chk_pair("t3 cleared", 0, 0, 1'b0, 1'b0);

        // T4: underflow and simultaneous push+pop
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        chk_pair("t4 unf", 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h222);
        chk_pair("t4 replace", 1, 12'h222, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        chk_pair("t4 reclear", 0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'h333);
        chk_pair("t4 pp empty", 1, 12'h333, 1'b0, 1'b0);

        // T5: clear beats push; sticky flags survive clear
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h111);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h222);
        chk_pair("t5 two", 2, 12'h222, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 12'h444);
        chk_pair("t5 clear", 0, 0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 12'h555);
        chk_pair("t5 after", 1, 12'h555, 1'b0, 1'b1);

        // T6: generic geometry, fill to full then randomized traffic
        for (int i = 0; i < GD; i++) gen_cyc(1'b1, 1'b0, 1'b0, 1'b0, GW'($urandom));
        check("t6 filled", 32'(g_cnt), 32'(GD));
        for (int i = 0; i < 1000; i++) begin
            int unsigned r = $urandom_range(0, 99);
            int unsigned pp = (i < 500) ? 45 : 30;
            logic p = ($urandom_range(0, 99) < pp);
            logic q = ($urandom_range(0, 99) < 100 - pp - 10);
            logic c = (r < 2);
            logic e = (r >= 2 && r < 7);
            gen_cyc(p, q, c, e, GW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
